// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-control bus: hazard/EX requests toward the PC controller and the fetch status back.
// The master drives stall/redirect requests; the slave is the PC controller.
interface fetch_pc_ctrl_if #(
    parameter int WIDTH = 9
);
    logic             stall;
    logic             pc_sel;
    logic [31:0]      branch_pc;
    logic [WIDTH-1:0] pc;
    logic             if_valid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             halted;
    logic             misalign_err;
    logic [15:0]      redirect_cnt;

    modport master (
        output stall, pc_sel, branch_pc,
        input  pc, if_valid, flush_ifid, flush_idex, halted, misalign_err, redirect_cnt
    );

    modport slave (
        input  stall, pc_sel, branch_pc,
        output pc, if_valid, flush_ifid, flush_idex, halted, misalign_err, redirect_cnt
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program-counter controller for the fetch stage.
// Handles the warm-up cycle, sequential fetch, stalls, EX redirects, the halt redirect and misaligned targets.
module fetch_pc_ctrl #(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_ctrl_if.slave bus
);
    localparam logic [1:0]  ST_WARMUP  = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_HALTED  = 2'd2;
    localparam logic [31:0] HALT_TARGET = 32'hFFFF_FFFF;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             misalign_q, misalign_d;
    logic [15:0]      cnt_q, cnt_d;

    logic in_run;
    logic is_halt_target;
    logic is_misaligned;
    logic take_halt;
    logic take_misalign;
    logic take_redirect;

    assign in_run         = (state_q == ST_RUN);
    assign is_halt_target = (bus.branch_pc == HALT_TARGET);
    assign is_misaligned  = (bus.branch_pc[1:0] != 2'b00);

    // The halt value is itself misaligned, so it is decoded first.
    assign take_halt     = in_run & bus.pc_sel & is_halt_target;
    assign take_misalign = in_run & bus.pc_sel & ~is_halt_target & is_misaligned;
    assign take_redirect = in_run & bus.pc_sel & ~is_halt_target & ~is_misaligned;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_WARMUP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (take_halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (take_misalign) begin
                    state_d    = ST_HALTED;
                    halted_d   = 1'b1;
                    misalign_d = 1'b1;
                end else if (take_redirect) begin
                    pc_d = bus.branch_pc[WIDTH-1:0];
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_q + WIDTH'(3'd4);
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WARMUP;
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Any accepted pc_sel in RUN (redirect, halt or misaligned) squashes the younger stages.
    assign bus.pc           = pc_q;
    assign bus.if_valid     = in_run & ~bus.stall & ~bus.pc_sel;
    assign bus.flush_ifid   = in_run & bus.pc_sel;
    assign bus.flush_idex   = in_run & bus.pc_sel;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_q;
    assign bus.redirect_cnt = cnt_q;
endmodule
